// File: rtl/vga_timing_pkg.sv
// Shared timing presets and sync polarity constants for the VGA raster generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vga_timing_t;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // 640x480@60 uses negative syncs, 800x600@60 positive ones
  localparam vga_timing_t VGA_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33
  };

  localparam vga_timing_t VGA_800X600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
  };

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus active/sync decode of its next value.
// Latency: decode outputs are combinational on the value the counter takes at the next edge.
// Backpressure: none; advances only when en is high.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] act,
  input  logic [W-1:0] sync_beg,
  input  logic [W-1:0] sync_end,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt_nxt,
  output logic         wrap,
  output logic         active_nxt,
  output logic         sync_nxt
);

  logic [W-1:0] cnt;

  assign wrap = en && (cnt >= last);

  always_comb begin
    cnt_nxt = cnt;
    if (en) cnt_nxt = wrap ? '0 : cnt + W'(1);
  end

  assign active_nxt = cnt_nxt < act;
  assign sync_nxt   = (cnt_nxt >= sync_beg) && (cnt_nxt < sync_end);

  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator; VGA_TIMING_PROG_EN adds a shadowed runtime timing set.
// Latency: outputs registered on the pix_ce edge and describe the counter values set by that edge.
// Backpressure: raster never stalls; cfg_ready stays low until a loaded set is applied at frame wrap.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_640X480_60.h_active,
  parameter int   H_FP     = VGA_640X480_60.h_fp,
  parameter int   H_SYNC   = VGA_640X480_60.h_sync,
  parameter int   H_BP     = VGA_640X480_60.h_bp,
  parameter int   V_ACTIVE = VGA_640X480_60.v_active,
  parameter int   V_FP     = VGA_640X480_60.v_fp,
  parameter int   V_SYNC   = VGA_640X480_60.v_sync,
  parameter int   V_BP     = VGA_640X480_60.v_bp,
  parameter int   H_WIDTH  = 10,
  parameter int   V_WIDTH  = 10,
  parameter logic HS_POL   = SYNC_ACTIVE_LOW,
  parameter logic VS_POL   = SYNC_ACTIVE_LOW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_ce,
`ifdef VGA_TIMING_PROG_EN
  input  logic [H_WIDTH-1:0] cfg_h_active,
  input  logic [H_WIDTH-1:0] cfg_h_fp,
  input  logic [H_WIDTH-1:0] cfg_h_sync,
  input  logic [H_WIDTH-1:0] cfg_h_bp,
  input  logic [V_WIDTH-1:0] cfg_v_active,
  input  logic [V_WIDTH-1:0] cfg_v_fp,
  input  logic [V_WIDTH-1:0] cfg_v_sync,
  input  logic [V_WIDTH-1:0] cfg_v_bp,
  input  logic               cfg_valid,
  output logic               cfg_ready,
`endif
  output logic               h_sync,
  output logic               v_sync,
  output logic               video_on,
  output logic [H_WIDTH-1:0] pixel_x,
  output logic [V_WIDTH-1:0] pixel_y,
  output logic               line_start,
  output logic               frame_start
);

  localparam logic [H_WIDTH-1:0] H_ACT_P  = H_WIDTH'(H_ACTIVE);
  localparam logic [H_WIDTH-1:0] H_SB_P   = H_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [H_WIDTH-1:0] H_SE_P   = H_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_WIDTH-1:0] H_LAST_P = H_WIDTH'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [V_WIDTH-1:0] V_ACT_P  = V_WIDTH'(V_ACTIVE);
  localparam logic [V_WIDTH-1:0] V_SB_P   = V_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [V_WIDTH-1:0] V_SE_P   = V_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_WIDTH-1:0] V_LAST_P = V_WIDTH'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  // Active timing set, held as boundaries so the axis decode needs only compares
  logic [H_WIDTH-1:0] h_act, h_sb, h_se, h_last;
  logic [V_WIDTH-1:0] v_act, v_sb, v_se, v_last;

  logic [H_WIDTH-1:0] h_cnt_nxt;
  logic [V_WIDTH-1:0] v_cnt_nxt;
  logic               h_wrap, h_act_nxt, h_sync_nxt;
  logic               v_wrap, v_act_nxt, v_sync_nxt;
  logic               vid_nxt;

`ifdef VGA_TIMING_PROG_EN
  logic [H_WIDTH-1:0] sh_h_act, sh_h_sb, sh_h_se, sh_h_last;
  logic [V_WIDTH-1:0] sh_v_act, sh_v_sb, sh_v_se, sh_v_last;

  // A load accepted on the wrap cycle itself waits for the following wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_act <= H_ACT_P;  h_sb <= H_SB_P;  h_se <= H_SE_P;  h_last <= H_LAST_P;
      v_act <= V_ACT_P;  v_sb <= V_SB_P;  v_se <= V_SE_P;  v_last <= V_LAST_P;
      sh_h_act <= H_ACT_P;  sh_h_sb <= H_SB_P;  sh_h_se <= H_SE_P;  sh_h_last <= H_LAST_P;
      sh_v_act <= V_ACT_P;  sh_v_sb <= V_SB_P;  sh_v_se <= V_SE_P;  sh_v_last <= V_LAST_P;
      cfg_ready <= 1'b1;
    end else if (v_wrap && !cfg_ready) begin
      h_act <= sh_h_act;  h_sb <= sh_h_sb;  h_se <= sh_h_se;  h_last <= sh_h_last;
      v_act <= sh_v_act;  v_sb <= sh_v_sb;  v_se <= sh_v_se;  v_last <= sh_v_last;
      cfg_ready <= 1'b1;
    end else if (cfg_valid && cfg_ready) begin
      sh_h_act  <= cfg_h_active;
      sh_h_sb   <= cfg_h_active + cfg_h_fp;
      sh_h_se   <= cfg_h_active + cfg_h_fp + cfg_h_sync;
      sh_h_last <= cfg_h_active + cfg_h_fp + cfg_h_sync + cfg_h_bp - H_WIDTH'(1);
      sh_v_act  <= cfg_v_active;
      sh_v_sb   <= cfg_v_active + cfg_v_fp;
      sh_v_se   <= cfg_v_active + cfg_v_fp + cfg_v_sync;
      sh_v_last <= cfg_v_active + cfg_v_fp + cfg_v_sync + cfg_v_bp - V_WIDTH'(1);
      cfg_ready <= 1'b0;
    end
  end
`else
  assign h_act  = H_ACT_P;
  assign h_sb   = H_SB_P;
  assign h_se   = H_SE_P;
  assign h_last = H_LAST_P;
  assign v_act  = V_ACT_P;
  assign v_sb   = V_SB_P;
  assign v_se   = V_SE_P;
  assign v_last = V_LAST_P;
`endif

  vga_axis_counter #(.W(H_WIDTH)) u_h_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (pix_ce),
    .act        (h_act),
    .sync_beg   (h_sb),
    .sync_end   (h_se),
    .last       (h_last),
    .cnt_nxt    (h_cnt_nxt),
    .wrap       (h_wrap),
    .active_nxt (h_act_nxt),
    .sync_nxt   (h_sync_nxt)
  );

  vga_axis_counter #(.W(V_WIDTH)) u_v_axis (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (h_wrap),
    .act        (v_act),
    .sync_beg   (v_sb),
    .sync_end   (v_se),
    .last       (v_last),
    .cnt_nxt    (v_cnt_nxt),
    .wrap       (v_wrap),
    .active_nxt (v_act_nxt),
    .sync_nxt   (v_sync_nxt)
  );

  assign vid_nxt = h_act_nxt && v_act_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_sync      <= ~HS_POL;
      v_sync      <= ~VS_POL;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (pix_ce) begin
        h_sync   <= h_sync_nxt ? HS_POL : ~HS_POL;
        v_sync   <= v_sync_nxt ? VS_POL : ~VS_POL;
        video_on <= vid_nxt;
        pixel_x  <= vid_nxt ? h_cnt_nxt : '0;
        pixel_y  <= vid_nxt ? v_cnt_nxt : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x8 raster, both sync polarities.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_ce;
  logic       h_sync, v_sync, video_on, line_start, frame_start;
  logic [3:0] pixel_x;
  logic [2:0] pixel_y;
  logic       hs_p, vs_p, von_p, ls_p, fs_p;
  logic [3:0] px_p;
  logic [2:0] py_p;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

`ifdef VGA_TIMING_PROG_EN
  logic [3:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [2:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic       cfg_valid, cfg_ready, cfg_ready_p;
`endif

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_WIDTH(4), .V_WIDTH(3), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
`ifdef VGA_TIMING_PROG_EN
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
`endif
    .h_sync(h_sync), .v_sync(v_sync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_WIDTH(4), .V_WIDTH(3), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
`ifdef VGA_TIMING_PROG_EN
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_valid(1'b0), .cfg_ready(cfg_ready_p),
`endif
    .h_sync(hs_p), .v_sync(vs_p), .video_on(von_p),
    .pixel_x(px_p), .pixel_y(py_p),
    .line_start(ls_p), .frame_start(fs_p)
  );

  // Expected outputs after k pix_ce pulses from reset (h = k mod 14, v = k/14 mod 8)
  typedef struct {
    int k;
    bit hs, vs, von;
    int px, py;
    bit ls, fs;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV] = '{
    '{  1, 1, 1, 1, 1, 0, 0, 0},
    '{  7, 1, 1, 1, 7, 0, 0, 0},
    '{  8, 1, 1, 0, 0, 0, 0, 0},
    '{ 10, 0, 1, 0, 0, 0, 0, 0},
    '{ 12, 0, 1, 0, 0, 0, 0, 0},
    '{ 13, 1, 1, 0, 0, 0, 0, 0},
    '{ 14, 1, 1, 1, 0, 1, 1, 0},
    '{ 15, 1, 1, 1, 1, 1, 0, 0},
    '{ 47, 1, 1, 1, 5, 3, 0, 0},
    '{ 58, 1, 1, 0, 0, 0, 0, 0},
    '{ 70, 1, 0, 0, 0, 0, 1, 0},
    '{ 83, 1, 0, 0, 0, 0, 0, 0},
    '{ 84, 1, 0, 0, 0, 0, 1, 0},
    '{ 98, 1, 1, 0, 0, 0, 1, 0},
    '{112, 1, 1, 1, 0, 0, 1, 1},
    '{113, 1, 1, 1, 1, 0, 0, 0}
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pulse(1'b1);
    pulse(1'b1);
    rst_n = 1'b1;
    pix_ce = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hs"},  32'(h_sync),      32'd1);
    chk({tag, "_vs"},  32'(v_sync),      32'd1);
    chk({tag, "_von"}, 32'(video_on),    32'd0);
    chk({tag, "_px"},  32'(pixel_x),     32'd0);
    chk({tag, "_py"},  32'(pixel_y),     32'd0);
    chk({tag, "_ls"},  32'(line_start),  32'd0);
    chk({tag, "_fs"},  32'(frame_start), 32'd0);
    chk({tag, "_hsp"}, 32'(hs_p),        32'd0);
    chk({tag, "_vsp"}, 32'(vs_p),        32'd0);
    chk({tag, "_prest"}, 32'({von_p, px_p, py_p, ls_p, fs_p}), 32'd0);
`ifdef VGA_TIMING_PROG_EN
    chk({tag, "_rdy"}, 32'({cfg_ready, cfg_ready_p}), 32'd3);
`endif
  endtask

  task automatic chk_vec(input int i, input bit alt, input bit idle);
    string t;
    bit    ls_e, fs_e;
    t    = $sformatf("%s%0d%s", alt ? "alt" : "run", tbl[i].k, idle ? "i" : "");
    ls_e = idle ? 1'b0 : tbl[i].ls;
    fs_e = idle ? 1'b0 : tbl[i].fs;
    chk({t, "_hs"},  32'(h_sync),      32'(tbl[i].hs));
    chk({t, "_vs"},  32'(v_sync),      32'(tbl[i].vs));
    chk({t, "_von"}, 32'(video_on),    32'(tbl[i].von));
    chk({t, "_px"},  32'(pixel_x),     32'(tbl[i].px));
    chk({t, "_py"},  32'(pixel_y),     32'(tbl[i].py));
    chk({t, "_ls"},  32'(line_start),  32'(ls_e));
    chk({t, "_fs"},  32'(frame_start), 32'(fs_e));
    chk({t, "_hsp"}, 32'(hs_p),        32'(!tbl[i].hs));
    chk({t, "_vsp"}, 32'(vs_p),        32'(!tbl[i].vs));
    chk({t, "_prest"}, 32'({von_p, px_p, py_p, ls_p, fs_p}),
        32'({tbl[i].von, 4'(tbl[i].px), 3'(tbl[i].py), ls_e, fs_e}));
  endtask

  // Walks the table; in alt mode every pulse is preceded by an idle cycle
  task automatic run_table(input bit alt);
    int cur = 0;
    for (int i = 0; i < NV; i++) begin
      while (cur < tbl[i].k) begin
        if (alt) pulse(1'b0);
        pulse(1'b1);
        cur++;
      end
      chk_vec(i, alt, 1'b0);
      if (alt) begin
        pulse(1'b0);
        chk_vec(i, alt, 1'b1);
      end
    end
    pix_ce = 1'b0;
  endtask

  // Clock count between two consecutive strobes; -1 if the budget runs out
  task automatic strobe_gap(input bit alt, input bit frame, output int gap);
    int first = -1;
    gap = -1;
    for (int n = 0; n < 600 && gap < 0; n++) begin
      pulse(alt ? logic'(n % 2) : 1'b1);
      if (frame ? frame_start : line_start) begin
        if (first < 0) first = n;
        else           gap = n - first;
      end
    end
    pix_ce = 1'b0;
  endtask

  initial begin
    int gap;
    rst_n  = 1'b0;
    pix_ce = 1'b0;
`ifdef VGA_TIMING_PROG_EN
    cfg_valid = 1'b0;
    cfg_h_active = 4'd8; cfg_h_fp = 4'd2; cfg_h_sync = 4'd3; cfg_h_bp = 4'd1;
    cfg_v_active = 3'd4; cfg_v_fp = 3'd1; cfg_v_sync = 3'd2; cfg_v_bp = 3'd1;
`endif
    do_reset();
    chk_reset("rst0");

    run_table(1'b0);

    // Reset mid-line with pix_ce held high
    rst_n = 1'b0;
    pulse(1'b1);
    chk_reset("rstmid");
    rst_n = 1'b1;
    pulse(1'b1);
    chk("rstmid_first_px",  32'(pixel_x),  32'd1);
    chk("rstmid_first_von", 32'(video_on), 32'd1);

    do_reset();
    run_table(1'b1);

    do_reset();
    strobe_gap(1'b0, 1'b0, gap);
    chk("line_period", 32'(gap), 32'd14);
    do_reset();
    strobe_gap(1'b0, 1'b1, gap);
    chk("frame_period", 32'(gap), 32'd112);
    do_reset();
    strobe_gap(1'b1, 1'b0, gap);
    chk("line_period_alt", 32'(gap), 32'd28);
    do_reset();
    strobe_gap(1'b1, 1'b1, gap);
    chk("frame_period_alt", 32'(gap), 32'd224);

`ifdef VGA_TIMING_PROG_EN
    do_reset();
    repeat (20) pulse(1'b1);
    cfg_h_active = 4'd6;
    cfg_valid    = 1'b1;
    pulse(1'b0);
    cfg_valid    = 1'b0;
    chk("prog_rdy_low", 32'(cfg_ready), 32'd0);
    repeat (14) pulse(1'b1);               // k=34: h6 v2, still active under old timing
    chk("prog_old_von", 32'(video_on), 32'd1);
    chk("prog_old_px",  32'(pixel_x),  32'd6);
    repeat (77) pulse(1'b1);               // k=111: h13 v7
    chk("prog_pre_ls",  32'(line_start), 32'd0);
    chk("prog_pre_rdy", 32'(cfg_ready),  32'd0);
    pulse(1'b1);                           // k=112: frame wrap
    chk("prog_wrap_fs",  32'(frame_start), 32'd1);
    chk("prog_wrap_rdy", 32'(cfg_ready),   32'd1);
    repeat (5) pulse(1'b1);                // h5
    chk("prog_new_px5", 32'(pixel_x), 32'd5);
    pulse(1'b1);                           // h6 now blanking
    chk("prog_new_von6", 32'(video_on), 32'd0);
    repeat (2) pulse(1'b1);                // h8 now in sync
    chk("prog_new_hs8", 32'(h_sync), 32'd0);
    repeat (4) pulse(1'b1);                // line wrap after 12 pixels
    chk("prog_new_ls", 32'(line_start), 32'd1);
    chk("prog_new_py", 32'(pixel_y),    32'd1);
    chk("prog_new_px", 32'(pixel_x),    32'd0);
    pix_ce = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
